// File: rtl/fp16_pkg.sv
// Shared constants and types for the FP16 adder normalise/round stage.
// Optional build macro used by this slice: FP16_NR_LZC_EN.
package fp16_pkg;

    localparam int unsigned FP16_EXP_W   = 5;
    localparam int unsigned FP16_FRAC_W  = 10;
    localparam int unsigned FP16_EXP_MAX = 31;

    // Bit positions inside the raw 15-bit significand {C, H, M[9:0], G, R, S}
    localparam int unsigned BIT_C  = 14;
    localparam int unsigned BIT_H  = 13;
    localparam int unsigned BIT_M0 = 3;
    localparam int unsigned BIT_G  = 2;
    localparam int unsigned BIT_R  = 1;
    localparam int unsigned BIT_S  = 0;

    localparam logic [15:0] POS_ZERO = 16'h0000;
    localparam logic [9:0]  INF_FRAC = 10'h000;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        NORM,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/fp16_lzc.sv
// Combinational leading-zero counter; all-zero input yields W.
// Used only when FP16_NR_LZC_EN is defined.
module fp16_lzc #(
    parameter int unsigned W = 14
) (
    input  logic [W-1:0]              data_i,
    output logic [$clog2(W+1)-1:0]    count_o
);

    localparam int unsigned CW = $clog2(W + 1);

    logic found;

    always_comb begin
        count_o = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (!found) begin
                if (data_i[W-1-i]) begin
                    found = 1'b1;
                end else begin
                    count_o = count_o + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fp16_normalize_round.sv
// FP16 adder post-add stage: renormalise the raw significand sum, round to
// nearest-even and emit a packed half. FP16_NR_LZC_EN selects one-shot normalise.
module fp16_normalize_round
    import fp16_pkg::*;
#(
    parameter int unsigned EXP_W   = FP16_EXP_W,
    parameter int unsigned FRAC_W  = FP16_FRAC_W,
    parameter int unsigned EXP_MAX = FP16_EXP_MAX
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXP_W-1:0]         in_exp,
    input  logic [FRAC_W+4:0]        in_mant,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+FRAC_W:0]    out_result,
    output logic                     out_inexact,
    output logic                     out_overflow
);

    localparam int unsigned MANT_W = FRAC_W + 5;
    localparam int unsigned SIG_W  = FRAC_W + 4;
    localparam int unsigned IDX_C  = MANT_W - 1;
    localparam int unsigned IDX_H  = MANT_W - 2;
    localparam int unsigned RES_W  = EXP_W + FRAC_W + 1;

    localparam logic [EXP_W:0]   EXP_ONE  = (EXP_W+1)'(1);
    localparam logic [EXP_W:0]   EXP_INF  = (EXP_W+1)'(EXP_MAX);
    localparam logic [EXP_W-1:0] EXP_ALL1 = EXP_W'(EXP_MAX);

    state_t              state_q;
    logic                sign_q;
    logic [EXP_W:0]      exp_q;
    logic [MANT_W-1:0]   mant_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [RES_W-1:0]    result_q;
    logic                inexact_q;
    logic                overflow_q;

    logic [MANT_W-1:0]   carry_mant;
    logic [EXP_W:0]      carry_exp;
    logic [MANT_W-1:0]   norm_mant;
    logic [EXP_W:0]      norm_exp;
    logic                rnd_up;
    logic [FRAC_W+1:0]   rnd_sum;
    logic [FRAC_W:0]     rnd_sig;
    logic [EXP_W:0]      rnd_exp;
    logic [EXP_W-1:0]    rnd_exp_field;
    logic                rnd_ovf;
    logic [RES_W-1:0]    rnd_result;

    always_comb begin
        // Right shift on carry-out keeps everything below the new G as sticky
        carry_mant = {1'b0, mant_q[IDX_C:2], mant_q[BIT_R] | mant_q[BIT_S]};
        carry_exp  = exp_q + EXP_ONE;

        norm_mant  = {1'b0, mant_q[IDX_H-1:0], 1'b0};
        norm_exp   = exp_q - EXP_ONE;

        rnd_up  = mant_q[BIT_G] & (mant_q[BIT_R] | mant_q[BIT_S] | mant_q[BIT_M0]);
        rnd_sum = {1'b0, mant_q[IDX_H:BIT_M0]} + {{(FRAC_W+1){1'b0}}, rnd_up};
        rnd_sig = rnd_sum[FRAC_W+1] ? {1'b1, {FRAC_W{1'b0}}} : rnd_sum[FRAC_W:0];
        rnd_exp = rnd_sum[FRAC_W+1] ? exp_q + EXP_ONE : exp_q;
        rnd_ovf = (rnd_exp >= EXP_INF);
        // Subnormals (and subnormals that round into H) fall out of the H test
        rnd_exp_field = rnd_sig[FRAC_W] ? rnd_exp[EXP_W-1:0] : '0;
        rnd_result = rnd_ovf ? {sign_q, EXP_ALL1, INF_FRAC}
                             : {sign_q, rnd_exp_field, rnd_sig[FRAC_W-1:0]};
    end

`ifdef FP16_NR_LZC_EN
    logic [$clog2(SIG_W+1)-1:0] lzc_count;
    logic [EXP_W:0]             lzc_ext;
    logic [EXP_W:0]             exp_m1;
    logic [EXP_W:0]             lzc_shamt;
    logic [SIG_W-1:0]           lzc_sig;

    fp16_lzc #(
        .W (SIG_W)
    ) u_lzc (
        .data_i  (mant_q[IDX_H:0]),
        .count_o (lzc_count)
    );

    always_comb begin
        lzc_ext   = (EXP_W+1)'(lzc_count);
        exp_m1    = exp_q - EXP_ONE;
        lzc_shamt = (lzc_ext < exp_m1) ? lzc_ext : exp_m1;
        lzc_sig   = mant_q[IDX_H:0] << lzc_shamt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= POS_ZERO;
            inexact_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q     <= in_sign;
                        exp_q      <= (in_exp == '0) ? EXP_ONE : {1'b0, in_exp};
                        mant_q     <= in_mant;
                        in_ready_q <= 1'b0;
                        state_q    <= PRE;
                    end
                end
                PRE: begin
                    if (mant_q == '0) begin
                        result_q   <= POS_ZERO;
                        inexact_q  <= 1'b0;
                        overflow_q <= 1'b0;
                        state_q    <= DONE;
                    end else if (mant_q[IDX_C]) begin
                        if (carry_exp == EXP_INF) begin
                            result_q   <= {sign_q, EXP_ALL1, INF_FRAC};
                            inexact_q  <= 1'b0;
                            overflow_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            mant_q  <= carry_mant;
                            exp_q   <= carry_exp;
                            state_q <= ROUND;
                        end
                    end else if (!mant_q[IDX_H] && (exp_q > EXP_ONE)) begin
`ifdef FP16_NR_LZC_EN
                        // One-shot normalise folded into PRE to keep the fixed latency
                        mant_q  <= {1'b0, lzc_sig};
                        exp_q   <= exp_q - lzc_shamt;
                        state_q <= ROUND;
`else
                        state_q <= NORM;
`endif
                    end else begin
                        state_q <= ROUND;
                    end
                end
                NORM: begin
                    mant_q <= norm_mant;
                    exp_q  <= norm_exp;
                    if (norm_mant[IDX_H] || (norm_exp == EXP_ONE)) begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    result_q   <= rnd_result;
                    inexact_q  <= mant_q[BIT_G] | mant_q[BIT_R] | mant_q[BIT_S];
                    overflow_q <= rnd_ovf;
                    state_q    <= DONE;
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_result   = result_q;
    assign out_inexact  = inexact_q;
    assign out_overflow = overflow_q;

endmodule

// File: tb/tb_fp16_normalize_round.sv
// Self-checking bench for fp16_normalize_round: directed cases, random cases
// against an exact-arithmetic rounding model, backpressure and mid-op reset.
module tb_fp16_normalize_round;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [4:0]  in_exp;
    logic [14:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_inexact;
    logic        out_overflow;

    int total = 0;
    int bad   = 0;

    fp16_normalize_round dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mant      (in_mant),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_inexact  (out_inexact),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Exact value is mant * 2^(e-28); X = mant << (e-1) is that value in units of 2^-27.
    function automatic void ref_model(input logic s, input logic [4:0] e, input logic [14:0] m,
                                      output logic [15:0] res, output logic inx,
                                      output logic ovf, output int lat);
        int     eu;
        int     msb;
        int     ee;
        int     lz;
        longint x;
        longint ulp;
        longint q;
        longint rem;
        eu  = (e == 5'd0) ? 1 : int'(e);
        res = 16'h0000;
        inx = 1'b0;
        ovf = 1'b0;
        if (m == 15'd0) begin
            lat = 2;
            return;
        end
        x   = longint'(m) << (eu - 1);
        msb = 0;
        for (int i = 0; i < 63; i++) if (x[i]) msb = i;
        ee  = msb - 12;
        if (ee < 1) ee = 1;
        ulp = 64'd1 << (ee + 2);
        q   = x >> (ee + 2);
        rem = x & (ulp - 1);
        if ((rem > (ulp >> 1)) || ((rem == (ulp >> 1)) && q[0])) q = q + 1;
        if (q == 2048) begin
            q  = 1024;
            ee = ee + 1;
        end
        inx = (rem != 0);
        if (ee >= 31) begin
            ovf = 1'b1;
            res = {s, 5'h1F, 10'h000};
        end else begin
            res = {s, (q >= 1024) ? ee[4:0] : 5'd0, q[9:0]};
        end
        if (m[14]) begin
            lat = (eu + 1 >= 31) ? 2 : 3;
        end else begin
            lz = 0;
            for (int i = 13; i >= 0; i--) begin
                if (m[i]) break;
                lz++;
            end
            if (lz > eu - 1) lz = eu - 1;
`ifdef FP16_NR_LZC_EN
            lat = 3;
`else
            lat = 3 + lz;
`endif
        end
    endfunction

    task automatic drive_txn(input logic s, input logic [4:0] e, input logic [14:0] m,
                             output logic [15:0] r, output logic ix, output logic ov,
                             output int lat, output bit timeout);
        @(negedge clk);
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat     = 0;
        timeout = 1'b0;
        forever begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
            if (lat >= 40) begin
                timeout = 1'b1;
                break;
            end
        end
        r  = out_result;
        ix = out_inexact;
        ov = out_overflow;
    endtask

    task automatic ack_txn();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #3;
        total++; if (in_ready !== 1'b1)       begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0)      begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_result !== 16'h0000) begin bad++; $display("FAIL reset_result: got %h want 0000", out_result); end
        total++; if (out_inexact !== 1'b0)    begin bad++; $display("FAIL reset_inexact: got %b want 0", out_inexact); end
        total++; if (out_overflow !== 1'b0)   begin bad++; $display("FAIL reset_overflow: got %b want 0", out_overflow); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        s;
        logic [4:0]  e;
        logic [14:0] m;
        logic [15:0] res;
        logic        inx;
        logic        chk_inx;
        logic        ovf;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t        v[$];
        logic [15:0] r;
        logic        ix, ov;
        int          lat;
        bit          to;
        int          norm_lat;
`ifdef FP16_NR_LZC_EN
        norm_lat = 3;
`else
        norm_lat = 13;
`endif
        v.push_back('{1'b0, 5'd15, 15'h4000, 16'h4000, 1'b0, 1'b1, 1'b0, 3});
        v.push_back('{1'b0, 5'd15, 15'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2});
        v.push_back('{1'b1, 5'd15, 15'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2});
        v.push_back('{1'b0, 5'd15, 15'h0008, 16'h1400, 1'b0, 1'b1, 1'b0, norm_lat});
        v.push_back('{1'b0, 5'd15, 15'h200C, 16'h3C02, 1'b1, 1'b1, 1'b0, 3});
        v.push_back('{1'b0, 5'd15, 15'h2004, 16'h3C00, 1'b1, 1'b1, 1'b0, 3});
        v.push_back('{1'b0, 5'd30, 15'h7FF8, 16'h7C00, 1'b0, 1'b0, 1'b1, 2});
        v.push_back('{1'b1, 5'd30, 15'h7FF8, 16'hFC00, 1'b0, 1'b0, 1'b1, 2});
        v.push_back('{1'b0, 5'd1,  15'h1000, 16'h0200, 1'b0, 1'b1, 1'b0, 3});
        v.push_back('{1'b0, 5'd1,  15'h1FFC, 16'h0400, 1'b1, 1'b1, 1'b0, 3});
        v.push_back('{1'b0, 5'd0,  15'h1000, 16'h0200, 1'b0, 1'b1, 1'b0, 3});
        v.push_back('{1'b0, 5'd30, 15'h3FFC, 16'h7C00, 1'b1, 1'b1, 1'b1, 3});
        foreach (v[i]) begin
            drive_txn(v[i].s, v[i].e, v[i].m, r, ix, ov, lat, to);
            total++; if (to) begin bad++; $display("FAIL dir%0d_timeout: no out_valid within 40 cycles", i); end
            total++; if (r !== v[i].res) begin bad++; $display("FAIL dir%0d_result: got %h want %h", i, r, v[i].res); end
            total++; if (ov !== v[i].ovf) begin bad++; $display("FAIL dir%0d_overflow: got %b want %b", i, ov, v[i].ovf); end
            total++; if (lat != v[i].lat) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, v[i].lat); end
            if (v[i].chk_inx) begin
                total++; if (ix !== v[i].inx) begin bad++; $display("FAIL dir%0d_inexact: got %b want %b", i, ix, v[i].inx); end
            end
            ack_txn();
        end
    endtask

    task automatic test_random();
        logic [15:0] r, er;
        logic        ix, ov, eix, eov;
        int          lat, elat;
        bit          to;
        logic        s;
        logic [4:0]  e;
        logic [14:0] m;
        for (int n = 0; n < 300; n++) begin
            s = 1'($urandom);
            e = 5'($urandom_range(0, 30));
            m = 15'($urandom);
            if ($urandom_range(0, 1) == 1) m = m >> $urandom_range(1, 14);
            ref_model(s, e, m, er, eix, eov, elat);
            drive_txn(s, e, m, r, ix, ov, lat, to);
            total++; if (to) begin bad++; $display("FAIL rnd%0d_timeout: e=%0d m=%h", n, e, m); end
            total++; if (r !== er) begin bad++; $display("FAIL rnd%0d_result: s=%b e=%0d m=%h got %h want %h", n, s, e, m, r, er); end
            total++; if (ov !== eov) begin bad++; $display("FAIL rnd%0d_overflow: e=%0d m=%h got %b want %b", n, e, m, ov, eov); end
            total++; if (lat != elat) begin bad++; $display("FAIL rnd%0d_latency: e=%0d m=%h got %0d want %0d", n, e, m, lat, elat); end
            if (!eov) begin
                total++; if (ix !== eix) begin bad++; $display("FAIL rnd%0d_inexact: e=%0d m=%h got %b want %b", n, e, m, ix, eix); end
            end
            ack_txn();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] r;
        logic        ix, ov;
        int          lat;
        bit          to;
        drive_txn(1'b0, 5'd15, 15'h200C, r, ix, ov, lat, to);
        total++; if (to) begin bad++; $display("FAIL bp_timeout: no out_valid"); end
        @(negedge clk);
        in_valid = 1'b1;
        in_exp   = 5'd20;
        in_mant  = 15'h4000;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total++; if (out_result !== 16'h3C02) begin bad++; $display("FAIL bp_hold%0d_result: got %h want 3c02", c, out_result); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d_valid: got %b want 1", c, out_valid); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold%0d_in_ready: got %b want 0", c, in_ready); end
            total++; if (out_inexact !== 1'b1) begin bad++; $display("FAIL bp_hold%0d_inexact: got %b want 1", c, out_inexact); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        ack_txn();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_accept%0d: out_valid got %b want 0", c, out_valid); end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] r;
        logic        ix, ov;
        int          lat;
        bit          to;
        @(negedge clk);
        in_sign  = 1'b0;
        in_exp   = 5'd15;
        in_mant  = 15'h0008;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        total++; if (out_result !== 16'h0000) begin bad++; $display("FAIL midrst_result: got %h want 0000", out_result); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_abandon%0d: out_valid got %b want 0", c, out_valid); end
        end
        drive_txn(1'b1, 5'd15, 15'h0008, r, ix, ov, lat, to);
        total++; if (to) begin bad++; $display("FAIL midrst_recover_timeout: no out_valid"); end
        total++; if (r !== 16'h9400) begin bad++; $display("FAIL midrst_recover_result: got %h want 9400", r); end
        ack_txn();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
